// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiplier, LANES parallel MACs, valid/ready in and out.
// Optional: define MATMUL_SAT_EN for saturating results plus a sticky sat_flag port.
module matmul_seq #(
  parameter int MUL_SIZE = 8,
  parameter int DATA_W   = 8,
  parameter int LANES    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_W*MUL_SIZE*MUL_SIZE-1:0] a,
  input  logic [DATA_W*MUL_SIZE*MUL_SIZE-1:0] b,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_W*MUL_SIZE*MUL_SIZE-1:0] out,
  output logic busy
`ifdef MATMUL_SAT_EN
  ,
  output logic sat_flag
`endif
);

  localparam int N     = MUL_SIZE;
  localparam int NN    = N * N;
  localparam int W     = DATA_W * NN;
  localparam int G     = NN / LANES;
  localparam int ACC_W = 2 * DATA_W + $clog2(N);
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int AW    = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((NN % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide MUL_SIZE*MUL_SIZE");
  end

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      out_q, out_d;
  logic [KW-1:0]     k_q, k_d;
  logic [GW-1:0]     g_q, g_d;
  logic [ACC_W-1:0]  acc_q [LANES];
  logic [ACC_W-1:0]  acc_d [LANES];
`ifdef MATMUL_SAT_EN
  logic              sat_q, sat_d;
`endif

  int                e, i, j;
  logic [AW-1:0]     ai, bi, oi;
  logic [DATA_W-1:0] a_el, b_el, red;
  logic [ACC_W-1:0]  prod, sum;
  logic              last_k, last_g;

  assign last_k = (k_q == KW'(N - 1));
  assign last_g = (g_q == GW'(G - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    k_d     = k_q;
    g_d     = g_q;
    acc_d   = acc_q;
`ifdef MATMUL_SAT_EN
    sat_d   = sat_q;
`endif
    e    = 0;
    i    = 0;
    j    = 0;
    ai   = '0;
    bi   = '0;
    oi   = '0;
    a_el = '0;
    b_el = '0;
    prod = '0;
    sum  = '0;
    red  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          k_d     = '0;
          g_d     = '0;
          state_d = S_RUN;
`ifdef MATMUL_SAT_EN
          sat_d   = 1'b0;
`endif
          for (int l = 0; l < LANES; l++) begin
            acc_d[l] = '0;
          end
        end
      end
      S_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          e    = int'(g_q) * LANES + l;
          i    = e / N;
          j    = e % N;
          ai   = AW'((i * N + int'(k_q)) * DATA_W);
          bi   = AW'((int'(k_q) * N + j) * DATA_W);
          oi   = AW'(e * DATA_W);
          a_el = a_q[ai +: DATA_W];
          b_el = b_q[bi +: DATA_W];
          prod = ACC_W'(a_el) * ACC_W'(b_el);
          sum  = acc_q[l] + prod;
          if (last_k) begin
`ifdef MATMUL_SAT_EN
            if (sum > ACC_W'({DATA_W{1'b1}})) begin
              red   = '1;
              sat_d = 1'b1;
            end else begin
              red = sum[DATA_W-1:0];
            end
`else
            red = sum[DATA_W-1:0];
`endif
            out_d[oi +: DATA_W] = red;
            acc_d[l] = '0;
          end else begin
            acc_d[l] = sum;
          end
        end
        if (last_k) begin
          k_d = '0;
          g_d = g_q + GW'(1);
          if (last_g) state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      k_q     <= '0;
      g_q     <= '0;
`ifdef MATMUL_SAT_EN
      sat_q   <= 1'b0;
`endif
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      k_q     <= k_d;
      g_q     <= g_d;
`ifdef MATMUL_SAT_EN
      sat_q   <= sat_d;
`endif
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out       = out_q;
`ifdef MATMUL_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq: 8x8x8-bit main instance plus N=4, 16-bit
// instances with LANES of 1, 4 and 16.
module tb_matmul_seq;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int L  = 8;
  localparam int W  = DW * N * N;
`ifdef MATMUL_SAT_EN
  localparam logic [W-1:0] FF_EXP = {N*N{8'hFF}};
`else
  localparam logic [W-1:0] FF_EXP = {N*N{8'h08}};
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b, out;
`ifdef MATMUL_SAT_EN
  logic sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit sw_done[3];

  matmul_seq #(.MUL_SIZE(N), .DATA_W(DW), .LANES(L)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
`ifdef MATMUL_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ident(input int s);
    logic [W-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*DW +: DW] = DW'(s);
    return m;
  endfunction

  function automatic logic [W-1:0] ramp(input int s);
    logic [W-1:0] m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[(r*N+c)*DW +: DW] = DW'(s * (r*N+c));
    return m;
  endfunction

  function automatic logic [255:0] mm4(input logic [255:0] x, y,
                                       output bit st);
    logic [255:0] r;
    longint s;
    r = '0;
    st = 1'b0;
    for (int ii = 0; ii < 4; ii++)
      for (int jj = 0; jj < 4; jj++) begin
        s = 0;
        for (int kk = 0; kk < 4; kk++)
          s += longint'(x[(ii*4+kk)*16 +: 16]) * longint'(y[(kk*4+jj)*16 +: 16]);
`ifdef MATMUL_SAT_EN
        if (s > 65535) begin
          s = 65535;
          st = 1'b1;
        end
`endif
        r[(ii*4+jj)*16 +: 16] = 16'(s);
      end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 512'(exp_q.size()), 512'(1));
      else chk("sb_out", out, exp_q.pop_front());
    end
  end

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit keep);
    a = av;
    b = bv;
    in_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("acc_ready", 512'(in_ready), 512'(1));
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int lat);
    int cnt;
    bit low;
    cnt = 0;
    low = 1'b1;
    while (cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (in_ready) low = 1'b0;
      if (out_valid) break;
    end
    chk({nm, "_lat"}, 512'(cnt), 512'(lat));
    chk({nm, "_rdy_low"}, 512'(low), 512'(1));
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int SL = (gi == 0) ? 1 : (gi == 1) ? 4 : 16;
    logic srst, sv, srdy, svld, sor, sbusy;
    logic [255:0] sa, sb, so;
    logic [255:0] sq[$];
    bit sst;
`ifdef MATMUL_SAT_EN
    logic ssat;
`endif

    matmul_seq #(.MUL_SIZE(4), .DATA_W(16), .LANES(SL)) u_sw (
      .clk(clk), .rst(srst),
      .in_valid(sv), .in_ready(srdy),
      .a(sa), .b(sb),
      .out_valid(svld), .out_ready(sor),
      .out(so), .busy(sbusy)
`ifdef MATMUL_SAT_EN
      , .sat_flag(ssat)
`endif
    );

    always @(negedge clk) begin
      if (!srst && svld && sor) begin
        if (sq.size() == 0)
          chk($sformatf("sweep%0d_unexp", SL), 512'(sq.size()), 512'(1));
        else
          chk($sformatf("sweep%0d_out", SL), 512'(so), 512'(sq.pop_front()));
      end
    end

    initial begin
      int cnt;
      srst = 1'b1;
      sv = 1'b0;
      sor = 1'b1;
      sa = '0;
      sb = '0;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
      for (int e = 0; e < 16; e++) begin
        sa[e*16 +: 16] = 16'(e * 4099 + 7 + gi * 13);
        sb[e*16 +: 16] = 16'(e * 2311 + 1000);
      end
      sq.push_back(mm4(sa, sb, sst));
      sv = 1'b1;
      @(negedge clk);
      chk($sformatf("sweep%0d_rdy", SL), 512'(srdy), 512'(1));
      @(posedge clk);
      #1 sv = 1'b0;
      chk($sformatf("sweep%0d_busy", SL), 512'(sbusy), 512'(1));
      cnt = 0;
      while (cnt < 500) begin
        @(posedge clk);
        #1;
        cnt++;
        if (svld) break;
      end
      chk($sformatf("sweep%0d_lat", SL), 512'(cnt), 512'(64 / SL));
`ifdef MATMUL_SAT_EN
      chk($sformatf("sweep%0d_sat", SL), 512'(ssat), 512'(sst));
`endif
      repeat (3) @(posedge clk);
      chk($sformatf("sweep%0d_drained", SL), 512'(sq.size()), 512'(0));
      sw_done[gi] = 1'b1;
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_out", 512'(out), 512'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    accept(ident(1), ramp(1), 1'b0);
    exp_q.push_back(ramp(1));
    wait_valid("id", 64);
`ifdef MATMUL_SAT_EN
    chk("id_sat", 512'(sat_flag), 512'(0));
`endif
    @(posedge clk);
    #1;
    chk("id_idle", 512'(in_ready), 512'(1));

    accept('1, '1, 1'b0);
    exp_q.push_back(FF_EXP);
    wait_valid("ff", 64);
`ifdef MATMUL_SAT_EN
    chk("ff_sat", 512'(sat_flag), 512'(1));
`endif
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    accept(ident(1), ramp(1), 1'b0);
    exp_q.push_back(ramp(1));
    wait_valid("bp", 64);
    for (int t = 0; t < 10; t++) begin
      in_valid = t[0];
      a = ident(3);
      @(posedge clk);
      #1;
      chk("bp_valid", 512'(out_valid), 512'(1));
      chk("bp_out", 512'(out), 512'(ramp(1)));
      chk("bp_rdy", 512'(in_ready), 512'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle", 512'(in_ready), 512'(1));
    chk("bp_drop", 512'(out_valid), 512'(0));
    @(posedge clk);
    #1;
    chk("bp_no_queue", 512'(busy), 512'(0));

    accept(ident(1), ramp(1), 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mr_out", 512'(out), 512'(0));
    chk("mr_valid", 512'(out_valid), 512'(0));
    chk("mr_ready", 512'(in_ready), 512'(1));
    chk("mr_busy", 512'(busy), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    accept(ident(1), ramp(1), 1'b0);
    exp_q.push_back(ramp(1));
    wait_valid("rr", 64);
    @(posedge clk);
    #1;

    accept(ident(1), ramp(1), 1'b1);
    exp_q.push_back(ramp(1));
    a = ident(2);
    exp_q.push_back(ramp(2));
    cnt = 0;
    while (cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (in_ready) break;
    end
    chk("b2b_gap", 512'(cnt), 512'(65));
    @(posedge clk);
    #1;
    chk("b2b_accept", 512'(busy), 512'(1));
    in_valid = 1'b0;
    wait_valid("b2b2", 64);
    repeat (2) @(posedge clk);

    for (int t = 0; t < 2000; t++) begin
      if (sw_done[0] && sw_done[1] && sw_done[2]) break;
      @(posedge clk);
    end
    for (int s = 0; s < 3; s++)
      chk($sformatf("sweep_done%0d", s), 512'(sw_done[s]), 512'(1));
    chk("sb_drained", 512'(exp_q.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
